fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_pkg.sv | 17 +
 rtl/stream_buf3.sv | 49 ++++
 rtl/fifo_stream_reader.sv | 92 +++++++++
 tb/tb_fifo_stream_reader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared types and helpers for the FIFO stream reader
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 3;

    // Modulo-3 pointer advance for the output buffer.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/stream_buf3.sv
// rtl/stream_buf3.sv - 3-entry in-order word buffer with occupancy count
module stream_buf3
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              pop,
    output logic [DWIDTH-1:0] data_out,
    output logic [1:0]        occ
);

    logic [DWIDTH-1:0] mem [BUF_DEPTH];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;

    // Storage is not reset; occ alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign data_out = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - burst reader from a 1-cycle-latency FIFO into a valid/ready stream
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic              busy
);

    localparam int CW = $clog2(BURST);

    state_t            state;
    state_t            state_next;
    logic              inflight;
    logic [CW-1:0]     rd_cnt;
    logic [CW-1:0]     beat_cnt;
    logic [1:0]        occ;
    logic              read_allowed;
    logic              room;
    logic              pop;
    logic [DWIDTH-1:0] head;

    always_comb begin
        state_next   = state;
        read_allowed = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_next = RUN;
            end
            RUN: begin
                read_allowed = 1'b1;
                if (!en) state_next = DRAIN;
            end
            DRAIN: begin
                // Keep reading only to finish a partially issued burst.
                read_allowed = (rd_cnt != '0);
                if (en) begin
                    state_next = RUN;
                end else if (rd_cnt == '0 && !inflight && occ == 2'd0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reserve a buffer slot for the word still on its way from the FIFO.
    assign room       = ({1'b0, occ} + {2'b00, inflight}) < 3'd3;
    assign fifo_rd_en = rstn & !fifo_empty & read_allowed & room;

    assign m_valid = rstn & (occ != 2'd0);
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? head : '0;
    assign m_last  = m_valid & (beat_cnt == CW'(BURST - 1));
    assign busy    = rstn & (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            inflight <= 1'b0;
            rd_cnt   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            inflight <= fifo_rd_en;
            if (fifo_rd_en) rd_cnt <= rd_cnt + CW'(1);
            if (pop)        beat_cnt <= beat_cnt + CW'(1);
        end
    end

    stream_buf3 #(.DWIDTH(DWIDTH)) u_buf (
        .clk      (clk),
        .rstn     (rstn),
        .push     (inflight),
        .data_in  (fifo_dout),
        .pop      (pop),
        .data_out (head),
        .occ      (occ)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed and table-driven bench for fifo_stream_reader
module tb_fifo_stream_reader;

    localparam int DW = 16;
    localparam int BURST = 4;

    logic          clk;
    logic          rstn;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    fifo_stream_reader #(.DWIDTH(DW), .BURST(BURST)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO model: 1-cycle read latency, contents flushed by reset.
    logic [DW-1:0] fmem [4096];
    int            wr_idx = 0;
    int            rd_idx = 0;
    assign fifo_empty = (rd_idx == wr_idx);

    initial fifo_dout = '0;
    always @(posedge clk) begin
        if (!rstn) begin
            rd_idx <= wr_idx;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= fmem[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    typedef struct {
        logic          rstn;
        logic          en;
        logic          m_ready;
        logic          exp_rd;
        logic          exp_valid;
        logic          exp_last;
        logic          exp_busy;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t          tbl [15];
    logic [DW-1:0] exp_q [$];
    int            total = 0;
    int            bad = 0;
    int            reads = 0;
    int            rcv_cnt = 0;
    int            out_beat = 0;
    int            hold_err = 0;
    int            stall_cnt = 0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic          prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    function automatic vec_t mk(input int r, input int e, input int rdy, input int xrd,
                                input int xv, input int xl, input int xb, input int xd);
        vec_t v;
        v.rstn      = 1'(r);
        v.en        = 1'(e);
        v.m_ready   = 1'(rdy);
        v.exp_rd    = 1'(xrd);
        v.exp_valid = 1'(xv);
        v.exp_last  = 1'(xl);
        v.exp_busy  = 1'(xb);
        v.exp_data  = DW'(xd);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fmem[wr_idx] = w;
        wr_idx++;
        exp_q.push_back(w);
    endtask

    // Called mid-cycle: scoreboards transfers, counts reads, checks hold stability.
    task automatic sample();
        if (fifo_rd_en) reads++;
        if (!rstn) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                if (!m_valid || m_data !== prev_data || m_last !== prev_last) hold_err++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    chk("word", 32'(m_data), 32'(exp_q.pop_front()));
                    chk("last", 32'(m_last), 32'(out_beat == BURST - 1));
                end
                out_beat = (out_beat + 1) % BURST;
                rcv_cnt++;
            end
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            sample();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        en   = 1'b0;
        tick(2);
        rstn = 1'b1;
        exp_q.delete();
        out_beat = 0;
        reads    = 0;
        rcv_cnt  = 0;
    endtask

    initial begin
        rstn    = 1'b0;
        en      = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);

        // Reset values while rstn is low.
        #1;
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        @(negedge clk);
        do_reset();

        // Burst of 8 preloaded words at full rate, then en drop.
        tbl[0]  = mk(1, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 1, 1, 0, 0, 1, 0);
        tbl[3]  = mk(1, 1, 1, 1, 0, 0, 1, 0);
        tbl[4]  = mk(1, 1, 1, 1, 1, 0, 1, 1);
        tbl[5]  = mk(1, 1, 1, 1, 1, 0, 1, 2);
        tbl[6]  = mk(1, 1, 1, 1, 1, 0, 1, 3);
        tbl[7]  = mk(1, 1, 1, 1, 1, 1, 1, 4);
        tbl[8]  = mk(1, 1, 1, 1, 1, 0, 1, 5);
        tbl[9]  = mk(1, 1, 1, 1, 1, 0, 1, 6);
        tbl[10] = mk(1, 1, 1, 0, 1, 0, 1, 7);
        tbl[11] = mk(1, 1, 1, 0, 1, 1, 1, 8);
        tbl[12] = mk(1, 0, 1, 0, 0, 0, 1, 0);
        tbl[13] = mk(1, 0, 1, 0, 0, 0, 1, 0);
        tbl[14] = mk(1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        for (int i = 0; i < 15; i++) begin
            rstn    = tbl[i].rstn;
            en      = tbl[i].en;
            m_ready = tbl[i].m_ready;
            #1;
            chk($sformatf("v%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].exp_rd));
            chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("v%0d_data", i), 32'(m_data), 32'(tbl[i].exp_data));
            chk($sformatf("v%0d_last", i), 32'(m_last), 32'(tbl[i].exp_last));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            sample();
            @(negedge clk);
        end
        chk("t1_rcv", 32'(rcv_cnt), 8);

        // Backpressure: only 3 reads fit, head word held, burst completes on release.
        do_reset();
        for (int i = 0; i < 8; i++) push_word(DW'(16'h21 + i));
        en = 1'b1;
        m_ready = 1'b0;
        tick(12);
        chk("bp_reads", 32'(reads), 3);
        chk("bp_valid", 32'(m_valid), 1);
        chk("bp_data", 32'(m_data), 32'h21);
        m_ready = 1'b1;
        en = 1'b0;
        tick(15);
        chk("bp_reads_total", 32'(reads), 4);
        chk("bp_rcv", 32'(rcv_cnt), 4);
        chk("bp_busy", 32'(busy), 0);

        // en dropped after 2 reads: burst still completes with exactly 4 reads.
        do_reset();
        for (int i = 0; i < 8; i++) push_word(DW'(16'h31 + i));
        en = 1'b1;
        for (int i = 0; i < 10 && reads < 2; i++) tick(1);
        en = 1'b0;
        tick(15);
        chk("drop_reads", 32'(reads), 4);
        chk("drop_rcv", 32'(rcv_cnt), 4);
        chk("drop_busy", 32'(busy), 0);

        // FIFO runs dry after word 2 for 5 cycles, then is refilled.
        do_reset();
        push_word(16'h41);
        push_word(16'h42);
        en = 1'b1;
        tick(4);
        chk("dry_reads", 32'(reads), 2);
        tick(5);
        chk("dry_reads_stall", 32'(reads), 2);
        chk("dry_rcv_stall", 32'(rcv_cnt), 2);
        for (int i = 0; i < 6; i++) push_word(DW'(16'h43 + i));
        tick(10);
        en = 1'b0;
        tick(10);
        chk("dry_rcv", 32'(rcv_cnt), 8);
        chk("dry_busy", 32'(busy), 0);

        // Reset for one cycle with inflight=1 and occ=2.
        do_reset();
        for (int i = 0; i < 8; i++) push_word(DW'(16'h61 + i));
        en = 1'b1;
        m_ready = 1'b0;
        tick(4);
        rstn = 1'b0;
        en = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 0);
        chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
        sample();
        @(negedge clk);
        rstn = 1'b1;
        m_ready = 1'b1;
        exp_q.delete();
        out_beat = 0;
        reads = 0;
        rcv_cnt = 0;
        #1;
        chk("post_rst_valid", 32'(m_valid), 0);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_data", 32'(m_data), 0);
        sample();
        @(negedge clk);
        tick(6);
        chk("post_rst_rcv", 32'(rcv_cnt), 0);
        for (int i = 0; i < 4; i++) push_word(DW'(16'h51 + i));
        en = 1'b1;
        tick(3);
        en = 1'b0;
        tick(15);
        chk("post_rst_reads", 32'(reads), 4);
        chk("post_rst_rcv4", 32'(rcv_cnt), 4);
        chk("post_rst_idle", 32'(busy), 0);

        // Random backpressure over 1000 words with throughput check.
        do_reset();
        for (int i = 0; i < 1000; i++) push_word(DW'($urandom));
        en = 1'b1;
        begin
            logic seen_valid;
            seen_valid = 1'b0;
            for (int c = 0; c < 6000 && rcv_cnt < 1000; c++) begin
                m_ready = 1'($urandom_range(0, 1));
                #1;
                if (m_valid) seen_valid = 1'b1;
                if (seen_valid && m_ready && !fifo_empty && !m_valid) stall_cnt++;
                sample();
                @(negedge clk);
            end
        end
        chk("rnd_rcv", 32'(rcv_cnt), 1000);
        chk("rnd_stalls", 32'(stall_cnt), 0);
        en = 1'b0;
        m_ready = 1'b1;
        tick(8);
        chk("rnd_busy", 32'(busy), 0);
        chk("rnd_leftover", 32'(exp_q.size()), 0);
        chk("hold_stable", 32'(hold_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
